// File: rtl/sbox_pkg.sv
// Shared types and constants for the 2:1 switch box buffer.
package sbox_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam logic [1:0] BUF_DEPTH = 2'd2;

endpackage

// File: rtl/sbox_fifo2.sv
// Two-entry in-order FIFO; head register feeds the output directly.
module sbox_fifo2
    import sbox_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [SIZE-1:0] din,
    output logic [SIZE-1:0] dout,
    output logic [1:0]      count
);

    logic [SIZE-1:0] head_q, head_d;
    logic [SIZE-1:0] tail_q, tail_d;
    logic [1:0]      count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && (count_q < BUF_DEPTH);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b01: begin
                // Vacated slots are zeroed so an empty head reads as 0.
                head_d  = tail_q;
                tail_d  = '0;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = din;
                end else begin
                    tail_d = din;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                head_d = din;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = head_q;
    assign count = count_q;

endmodule

// File: rtl/sbox2x1_buf.sv
// 2:1 source-selecting merge through a 2-entry buffer with drain-on-switch.
// Define SBOX2X1_BUF_STATS_EN to add the saturating xfer_count output.
module sbox2x1_buf
    import sbox_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SIZE-1:0] in1_data,
    input  logic            in1_write,
    output logic            in1_full_n,
    input  logic [SIZE-1:0] in2_data,
    input  logic            in2_write,
    output logic            in2_full_n,
    output logic [SIZE-1:0] out1_data,
    output logic            out1_write,
    input  logic            out1_full_n,
    input  logic            sel
`ifdef SBOX2X1_BUF_STATS_EN
    ,
    output logic [15:0]     xfer_count
`endif
);

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic            hold_q, hold_d;
    logic            live;
    logic            push;
    logic [SIZE-1:0] push_data;
    logic [SIZE-1:0] fifo_dout;
    logic [1:0]      fifo_count;

    // Ports stay blanked while reset is low and for the cycle after it.
    assign live       = reset && !hold_q;
    assign in1_full_n = live && (state_q == RUN) && !sel_q
                        && (fifo_count < BUF_DEPTH);
    assign in2_full_n = live && (state_q == RUN) && sel_q
                        && (fifo_count < BUF_DEPTH);
    assign out1_write = live && (fifo_count != 2'd0) && out1_full_n;
    assign out1_data  = live ? fifo_dout : '0;

    assign push      = (in1_write && in1_full_n)
                       || (in2_write && in2_full_n);
    assign push_data = sel_q ? in2_data : in1_data;

    sbox_fifo2 #(
        .SIZE (SIZE)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (out1_write),
        .din   (push_data),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = !reset;
        unique case (state_q)
            RUN: begin
                if (sel != sel_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_count == 2'd0) begin
                    sel_d   = sel;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            sel_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

`ifdef SBOX2X1_BUF_STATS_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (out1_write && (xfer_count_q != 16'hFFFF)) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            xfer_count_q <= 16'd0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule
